// File: rtl/d_kes_pe_sequencer.sv
// KES PE-array sequencer: one-hot FSM issuing RESET/DC/ELU strobes for T iterations, then done/ack.
// Optional `D_KES_SEQ_ERR_CNT_EN adds o_error_count (index of highest set degree-check bit).
module d_kes_pe_sequencer #(
   parameter int unsigned T      = 14,
   parameter int unsigned DC_LAT = 2
) (
   input  logic         i_clk,
   input  logic         i_RESET_n,
   input  logic         i_stop_dec,
   input  logic         i_execute_KES,
   output logic         o_KES_available,
   output logic         o_RESET_KES,
   output logic         o_EXECUTE_PE_DC,
   output logic         o_EXECUTE_PE_ELU,
   output logic [4:0]   o_iter_cnt,
   input  logic [T:0]   i_v_deg_chk_bits,
   output logic         o_KES_done,
   input  logic         i_KES_done_ack
`ifdef D_KES_SEQ_ERR_CNT_EN
   ,
   output logic [4:0]   o_error_count
`endif
);

   localparam logic [4:0] ITER_LAST = 5'(T - 1);
   localparam logic [3:0] WAIT_LOAD = 4'(DC_LAT - 1);

   typedef enum logic [6:0] {
      S_IDLE     = 7'b0000001,
      S_INIT     = 7'b0000010,
      S_DC_EXEC  = 7'b0000100,
      S_DC_WAIT  = 7'b0001000,
      S_ELU_EXEC = 7'b0010000,
      S_ELU_WAIT = 7'b0100000,
      S_DONE     = 7'b1000000
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic [4:0]  iter_q, iter_d;
   logic        last_iter_s;
   logic        avail_q, avail_d;
   logic        rst_kes_q, rst_kes_d;
   logic        dc_q, dc_d;
   logic        elu_q, elu_d;
   logic        done_q, done_d;

   assign last_iter_s = (iter_q == ITER_LAST);

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_RESET_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides every transition
   always_comb begin
      state_d = state_q;
      if (i_stop_dec) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_execute_KES) state_d = S_INIT;
               else               state_d = S_IDLE;
            end
            S_INIT:     state_d = S_DC_EXEC;
            S_DC_EXEC:  state_d = S_DC_WAIT;
            S_DC_WAIT: begin
               if (wait_q == 4'd0) state_d = S_ELU_EXEC;
               else                state_d = S_DC_WAIT;
            end
            S_ELU_EXEC: state_d = S_ELU_WAIT;
            S_ELU_WAIT: begin
               if (last_iter_s) state_d = S_DONE;
               else             state_d = S_DC_EXEC;
            end
            S_DONE: begin
               if (i_KES_done_ack) state_d = S_IDLE;
               else                state_d = S_DONE;
            end
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // Output decode of the next state so each registered strobe lines up with its state
   always_comb begin
      avail_d   = 1'b0;
      rst_kes_d = 1'b0;
      dc_d      = 1'b0;
      elu_d     = 1'b0;
      done_d    = 1'b0;
      case (state_d)
         S_IDLE:     avail_d   = 1'b1;
         S_INIT:     rst_kes_d = 1'b1;
         S_DC_EXEC:  dc_d      = 1'b1;
         S_ELU_EXEC: elu_d     = 1'b1;
         S_DONE:     done_d    = 1'b1;
         default:    avail_d   = 1'b0;
      endcase
   end

   // Iteration and DC-latency counters
   always_comb begin
      if (i_stop_dec) begin
         iter_d = 5'd0;
      end else if ((state_q == S_IDLE) && i_execute_KES) begin
         iter_d = 5'd0;
      end else if ((state_q == S_ELU_WAIT) && !last_iter_s) begin
         iter_d = iter_q + 5'd1;
      end else begin
         iter_d = iter_q;
      end

      if (state_q == S_DC_EXEC) begin
         wait_d = WAIT_LOAD;
      end else if ((state_q == S_DC_WAIT) && (wait_q != 4'd0)) begin
         wait_d = wait_q - 4'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   // Counter and output registers
   always_ff @(posedge i_clk) begin
      if (!i_RESET_n) begin
         wait_q    <= 4'd0;
         iter_q    <= 5'd0;
         avail_q   <= 1'b1;
         rst_kes_q <= 1'b0;
         dc_q      <= 1'b0;
         elu_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         iter_q    <= iter_d;
         avail_q   <= avail_d;
         rst_kes_q <= rst_kes_d;
         dc_q      <= dc_d;
         elu_q     <= elu_d;
         done_q    <= done_d;
      end
   end

   assign o_KES_available  = avail_q;
   assign o_RESET_KES      = rst_kes_q;
   assign o_EXECUTE_PE_DC  = dc_q;
   assign o_EXECUTE_PE_ELU = elu_q;
   assign o_KES_done       = done_q;
   assign o_iter_cnt       = iter_q;

`ifdef D_KES_SEQ_ERR_CNT_EN
   logic [4:0] err_q, err_d;

   function automatic logic [4:0] msb_index(input logic [T:0] bits);
      logic [4:0] idx;
      idx = 5'd0;
      for (int k = 0; k <= int'(T); k++) begin
         if (bits[k]) idx = 5'(k);
         else         idx = idx;
      end
      return idx;
   endfunction

   // Capture in the final ELU_WAIT, hold through DONE, clear whenever heading to IDLE
   always_comb begin
      if (state_d == S_IDLE) begin
         err_d = 5'd0;
      end else if ((state_q == S_ELU_WAIT) && last_iter_s) begin
         err_d = msb_index(i_v_deg_chk_bits);
      end else begin
         err_d = err_q;
      end
   end

   // Error-count register
   always_ff @(posedge i_clk) begin
      if (!i_RESET_n) begin
         err_q <= 5'd0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_error_count = err_q;
`else
   logic unused_deg_chk_s;
   assign unused_deg_chk_s = ^i_v_deg_chk_bits;
`endif

endmodule

// File: tb/tb_d_kes_pe_sequencer.sv
// Bench for d_kes_pe_sequencer: two instances (T=14/DC_LAT=2 and T=1/DC_LAT=1) against a schedule model.
module tb_d_kes_pe_sequencer;
   localparam int T0 = 14;
   localparam int L0 = 2;
   localparam int T1 = 1;
   localparam int L1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, stop, exec, ack;
   logic [T0:0] deg0;
   logic [T1:0] deg1;
   wire [1:0] av_w, rk_w, dc_w, elu_w, dn_w;
   wire [4:0] it0, it1;
`ifdef D_KES_SEQ_ERR_CNT_EN
   wire [4:0] ec0, ec1;
`endif

   d_kes_pe_sequencer #(.T(T0), .DC_LAT(L0)) u0 (
      .i_clk(clk), .i_RESET_n(rst_n), .i_stop_dec(stop), .i_execute_KES(exec),
      .o_KES_available(av_w[0]), .o_RESET_KES(rk_w[0]), .o_EXECUTE_PE_DC(dc_w[0]),
      .o_EXECUTE_PE_ELU(elu_w[0]), .o_iter_cnt(it0), .i_v_deg_chk_bits(deg0),
      .o_KES_done(dn_w[0]), .i_KES_done_ack(ack)
`ifdef D_KES_SEQ_ERR_CNT_EN
      , .o_error_count(ec0)
`endif
   );

   d_kes_pe_sequencer #(.T(T1), .DC_LAT(L1)) u1 (
      .i_clk(clk), .i_RESET_n(rst_n), .i_stop_dec(stop), .i_execute_KES(exec),
      .o_KES_available(av_w[1]), .o_RESET_KES(rk_w[1]), .o_EXECUTE_PE_DC(dc_w[1]),
      .o_EXECUTE_PE_ELU(elu_w[1]), .o_iter_cnt(it1), .i_v_deg_chk_bits(deg1),
      .o_KES_done(dn_w[1]), .i_KES_done_ack(ack)
`ifdef D_KES_SEQ_ERR_CNT_EN
      , .o_error_count(ec1)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // model: mode 0 idle, 1 busy (c = cycles since start), 2 done
   int pT[2] = '{T0, T1};
   int pL[2] = '{L0, L1};
   int m_mode[2] = '{0, 0};
   int m_c[2] = '{0, 0};
   int m_iter[2] = '{0, 0};
   int m_err[2] = '{0, 0};
   int start_iv[2] = '{0, 0};
   int starts0[$];

   int rec_rst[2], rec_dc_first[2], rec_dc_last[2], rec_dc_n[2];
   int rec_elu_first[2], rec_elu_last[2], rec_done_first[2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int msb_of(input logic [31:0] v);
      for (int b = 31; b >= 0; b--) begin
         if (v[b]) return b;
      end
      return 0;
   endfunction

   task automatic model_step(input int i);
      int per, tot;
      per = pL[i] + 3;
      tot = 2 + pT[i] * per;
      if (!rst_n || stop) begin
         m_mode[i] = 0; m_iter[i] = 0; m_err[i] = 0;
      end else if (m_mode[i] == 0) begin
         if (exec) begin
            m_mode[i] = 1; m_c[i] = 1; m_iter[i] = 0; start_iv[i] = cyc;
            rec_rst[i] = -1; rec_dc_first[i] = -1; rec_dc_last[i] = -1; rec_dc_n[i] = 0;
            rec_elu_first[i] = -1; rec_elu_last[i] = -1; rec_done_first[i] = -1;
            if (i == 0) starts0.push_back(cyc);
         end
      end else if (m_mode[i] == 1) begin
         if (m_c[i] == tot - 1) m_err[i] = msb_of((i == 0) ? 32'(deg0) : 32'(deg1));
         m_c[i]++;
         if (m_c[i] == tot) begin
            m_mode[i] = 2; m_iter[i] = pT[i] - 1;
         end
      end else begin
         if (ack) begin
            m_mode[i] = 0; m_err[i] = 0;
         end
      end
   endtask

   task automatic compare_inst(input int i);
      int per, e_av, e_rk, e_dc, e_elu, e_dn, e_it, rel, a_it;
      per = pL[i] + 3;
      e_av = (m_mode[i] == 0); e_dn = (m_mode[i] == 2);
      e_rk = 0; e_dc = 0; e_elu = 0; e_it = m_iter[i];
      if (m_mode[i] == 1) begin
         if (m_c[i] == 1) begin
            e_rk = 1; e_it = 0;
         end else begin
            e_dc  = ((m_c[i] - 2) % per == 0);
            e_elu = ((m_c[i] - 2) % per == pL[i] + 1);
            e_it  = (m_c[i] - 2) / per;
         end
      end
      a_it = (i == 0) ? int'(it0) : int'(it1);
      chk($sformatf("u%0d.avail", i), int'(av_w[i]), e_av);
      chk($sformatf("u%0d.reset_kes", i), int'(rk_w[i]), e_rk);
      chk($sformatf("u%0d.exec_dc", i), int'(dc_w[i]), e_dc);
      chk($sformatf("u%0d.exec_elu", i), int'(elu_w[i]), e_elu);
      chk($sformatf("u%0d.done", i), int'(dn_w[i]), e_dn);
      chk($sformatf("u%0d.iter_cnt", i), a_it, e_it);
      chk($sformatf("u%0d.strobe_onehot", i), int'((int'(rk_w[i]) + int'(dc_w[i]) + int'(elu_w[i])) <= 1), 1);
`ifdef D_KES_SEQ_ERR_CNT_EN
      chk($sformatf("u%0d.err_cnt", i), (i == 0) ? int'(ec0) : int'(ec1), m_err[i]);
`endif
      rel = cyc - start_iv[i];
      if (rk_w[i]) rec_rst[i] = rel;
      if (dc_w[i]) begin
         if (rec_dc_first[i] < 0) rec_dc_first[i] = rel;
         rec_dc_last[i] = rel; rec_dc_n[i]++;
      end
      if (elu_w[i]) begin
         if (rec_elu_first[i] < 0) rec_elu_first[i] = rel;
         rec_elu_last[i] = rel;
      end
      if (dn_w[i] && rec_done_first[i] < 0) rec_done_first[i] = rel;
   endtask

   // Single compare process: advance the model on each edge, check just after
   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      cyc = cyc + 1;
      #1;
      compare_inst(0);
      compare_inst(1);
   end

   task automatic run_full(input string tag);
      int seen;
      @(negedge clk); exec = 1'b1; deg0 = 15'h000F; deg1 = 2'b11;
      @(negedge clk); exec = 1'b0;
      seen = 0;
      for (int n = 0; n < 200 && seen == 0; n++) begin
         @(negedge clk);
         if (dn_w[0]) seen = 1;
      end
      chk({tag, "_done_seen"}, seen, 1);
`ifdef D_KES_SEQ_ERR_CNT_EN
      chk({tag, "_err_cnt_lit"}, int'(ec0), 3);
`endif
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         chk({tag, "_done_held"}, int'(dn_w[0]), 1);
         chk({tag, "_avail_low"}, int'(av_w[0]), 0);
      end
      ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      chk({tag, "_avail_after_ack"}, int'(av_w[0]), 1);
      chk({tag, "_rst_cyc"}, rec_rst[0], 1);
      chk({tag, "_dc_first"}, rec_dc_first[0], 2);
      chk({tag, "_dc_last"}, rec_dc_last[0], 67);
      chk({tag, "_dc_count"}, rec_dc_n[0], 14);
      chk({tag, "_elu_first"}, rec_elu_first[0], 5);
      chk({tag, "_elu_last"}, rec_elu_last[0], 70);
      chk({tag, "_done_first"}, rec_done_first[0], 72);
      chk({tag, "_u1_dc"}, rec_dc_first[1], 2);
      chk({tag, "_u1_dc_count"}, rec_dc_n[1], 1);
      chk({tag, "_u1_elu"}, rec_elu_first[1], 4);
      chk({tag, "_u1_done"}, rec_done_first[1], 6);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stop = 1'b0; exec = 1'b0; ack = 1'b0; deg0 = '0; deg1 = '0;
      repeat (3) @(negedge clk);
      chk("reset_avail", int'(av_w[0]), 1);
      chk("reset_iter", int'(it0), 0);
      chk("reset_done", int'(dn_w[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_full("sched1");

      // abort in DC_WAIT of iteration 6 (relative cycle 33)
      @(negedge clk); exec = 1'b1;
      @(negedge clk); exec = 1'b0;
      repeat (32) @(negedge clk);
      stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      chk("stop_avail", int'(av_w[0]), 1);
      chk("stop_iter", int'(it0), 0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk("stop_no_elu", int'(elu_w[0]), 0);
         chk("stop_no_done", int'(dn_w[0]), 0);
      end
      run_full("sched2");

      // reset in ELU_EXEC of iteration 3 (relative cycle 20)
      @(negedge clk); exec = 1'b1;
      @(negedge clk); exec = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_rst_elu", int'(elu_w[0]), 1);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("rst_avail", int'(av_w[0]), 1);
      chk("rst_dc", int'(dc_w[0]), 0);
      chk("rst_elu", int'(elu_w[0]), 0);
      chk("rst_done", int'(dn_w[0]), 0);
      chk("rst_iter", int'(it0), 0);
      repeat (3) @(negedge clk);

      // back-to-back decodes
      starts0.delete();
      exec = 1'b1; ack = 1'b1;
      repeat (3 * 73 + 5) @(negedge clk);
      exec = 1'b0; ack = 1'b0;
      chk("b2b_start_count", int'(starts0.size() >= 3), 1);
      for (int k = 1; k < starts0.size(); k++) begin
         chk("b2b_spacing", starts0[k] - starts0[k - 1], 73);
      end
      repeat (80) @(negedge clk);
      ack = 1'b1;
      @(negedge clk); ack = 1'b0;

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         exec  = ($urandom_range(0, 3) == 0);
         ack   = ($urandom_range(0, 5) == 0);
         stop  = ($urandom_range(0, 79) == 0);
         rst_n = !($urandom_range(0, 149) == 0);
         deg0  = 15'($urandom);
         deg1  = 2'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1; stop = 1'b0; exec = 1'b0; ack = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
